axis_frame_parser: RTL

Receive-side counterpart of the sensor AXI-Stream packetizer. Consumes frames of the form header, timestamp, FRAME_LEN data words, footer (with tlast) on a 16-bit AXI-Stream slave. Validates frame structure and stores payloads of good frames in a ping-pong pair of line buffers. Exposes a registered random-access read port plus status and saturating error counters to the processing logic downstream.

---
 rtl/axis_frame_parser.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/axis_frame_parser.sv
// AXI-Stream frame parser: checks header/timestamp/payload/footer framing and
// stores good payloads in a ping-pong pair of line buffers with a registered read port.
module axis_frame_parser #(
    parameter int          FRAME_LEN    = 1024,
    parameter logic [15:0] HEADER_VALUE = 16'hAAAA,
    parameter logic [15:0] FOOTER_VALUE = 16'h5555,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                 master_clock,
    input  logic                 resetn,
    input  logic [15:0]          data_tdata,
    input  logic                 data_tvalid,
    input  logic                 data_tlast,
    output logic                 data_tready,
    input  logic [9:0]           rd_addr,
    output logic [15:0]          rd_data,
    input  logic                 rd_release,
    output logic                 frame_ready,
    output logic [15:0]          frame_timestamp,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] sync_err_cnt,
    output logic [CNT_WIDTH-1:0] len_err_cnt,
    output logic [CNT_WIDTH-1:0] ftr_err_cnt,
    output logic [CNT_WIDTH-1:0] ovf_cnt,
    output logic [3:0]           dbg_state
);

    localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [3:0] {
        HUNT       = 4'd0,
        TIME_STAMP = 4'd1,
        DATA       = 4'd2,
        FOOTER     = 4'd3,
        DISCARD    = 4'd4
    } state_t;

    state_t         state, state_nxt;
    logic           beat;
    logic           inc_sync, inc_len, inc_ftr, inc_ovf;
    logic           commit, ts_load, mem_we, release_ok;
    logic [AW-1:0]  word_idx;
    logic           wr_bank, rd_bank;
    logic [1:0]     bank_full, full_nxt;
    logic [15:0]    pending_ts;
    logic [15:0]    ts_bank [2];
    logic [15:0]    mem [2*FRAME_LEN];

    // The block never back-pressures; overload is handled by dropping frames.
    assign data_tready     = resetn;
    assign beat            = data_tvalid && data_tready;
    assign frame_ready     = bank_full[rd_bank];
    assign frame_timestamp = ts_bank[rd_bank];
    assign release_ok      = rd_release && bank_full[rd_bank];
    assign dbg_state       = state;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        inc_sync  = 1'b0;
        inc_len   = 1'b0;
        inc_ftr   = 1'b0;
        inc_ovf   = 1'b0;
        commit    = 1'b0;
        ts_load   = 1'b0;
        mem_we    = 1'b0;
        if (beat) begin
            case (state)
                HUNT: begin
                    if (data_tdata == HEADER_VALUE && !data_tlast) begin
                        if (bank_full[wr_bank]) begin
                            inc_ovf   = 1'b1;
                            state_nxt = DISCARD;
                        end else begin
                            state_nxt = TIME_STAMP;
                        end
                    end else begin
                        inc_sync = 1'b1;
                    end
                end
                TIME_STAMP: begin
                    if (data_tlast) begin
                        inc_len   = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        ts_load   = 1'b1;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    mem_we = 1'b1;
                    if (data_tlast) begin
                        inc_len   = 1'b1;
                        state_nxt = HUNT;
                    end else if (word_idx == AW'(FRAME_LEN - 1)) begin
                        state_nxt = FOOTER;
                    end
                end
                FOOTER: begin
                    if (!data_tlast) begin
                        inc_ftr   = 1'b1;
                        state_nxt = DISCARD;
                    end else if (data_tdata == FOOTER_VALUE) begin
                        commit    = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        inc_ftr   = 1'b1;
                        state_nxt = HUNT;
                    end
                end
                DISCARD: begin
                    if (data_tlast) state_nxt = HUNT;
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Commit and release always hit different banks, so both apply.
    always_comb begin
        full_nxt = bank_full;
        if (commit)     full_nxt[wr_bank] = 1'b1;
        if (release_ok) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            state        <= HUNT;
            word_idx     <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            bank_full    <= 2'b00;
            pending_ts   <= '0;
            ts_bank[0]   <= '0;
            ts_bank[1]   <= '0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            sync_err_cnt <= '0;
            len_err_cnt  <= '0;
            ftr_err_cnt  <= '0;
            ovf_cnt      <= '0;
        end else begin
            state      <= state_nxt;
            bank_full  <= full_nxt;
            frame_done <= commit;
            if (ts_load) begin
                pending_ts <= data_tdata;
                word_idx   <= '0;
            end else if (mem_we) begin
                word_idx <= word_idx + AW'(1);
            end
            if (commit) begin
                ts_bank[wr_bank] <= pending_ts;
                wr_bank          <= ~wr_bank;
                frame_cnt        <= sat_inc(frame_cnt);
            end
            if (release_ok) rd_bank      <= ~rd_bank;
            if (inc_sync)   sync_err_cnt <= sat_inc(sync_err_cnt);
            if (inc_len)    len_err_cnt  <= sat_inc(len_err_cnt);
            if (inc_ftr)    ftr_err_cnt  <= sat_inc(ftr_err_cnt);
            if (inc_ovf)    ovf_cnt      <= sat_inc(ovf_cnt);
        end
    end

    always_ff @(posedge master_clock) begin
        if (mem_we) mem[{wr_bank, word_idx}] <= data_tdata;
    end

    always_ff @(posedge master_clock) begin
        if (!resetn) rd_data <= '0;
        else         rd_data <= mem[{rd_bank, rd_addr[AW-1:0]}];
    end

endmodule
